// File: rtl/sccb_target_responder_if.sv
// SCCB target bus bundle.
// Carries the pad-side SCCB lines and the register-access side of the responder.
//   SIOC_i   : SCCB clock as seen at the pad
//   SIOD_i   : SCCB data as seen at the pad
//   SIOD_oe  : 1 = pad pulls SIOD low, 0 = released (open drain)
//   busy     : high from START until STOP or abort
//   wr_valid : one-cycle register-write strobe
//   wr_addr  : write address, valid with wr_valid
//   wr_data  : write data, valid with wr_valid
//   rd_addr  : current read address (0 when reads are disabled)
//   rd_data  : register contents at rd_addr, combinational from the owner
// Modport slave is the responder; modport master is the bus/register owner side.
interface sccb_target_responder_if;
  logic        SIOC_i;
  logic        SIOD_i;
  logic        SIOD_oe;
  logic        busy;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;

  modport slave (
    input  SIOC_i, SIOD_i, rd_data,
    output SIOD_oe, busy, wr_valid, wr_addr, wr_data, rd_addr
  );

  modport master (
    output SIOC_i, SIOD_i, rd_data,
    input  SIOD_oe, busy, wr_valid, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/sccb_target_responder.sv
// SCCB target (camera-side) responder, an OV5640 stand-in.
// Oversamples SIOC/SIOD on clk_sys, decodes ID / 16-bit address / data bytes, ACKs by
// pulling SIOD low and emits register writes as a one-cycle strobe.
// Ports:
//   clk_sys : system clock, SCCB lines are oversampled on it
//   reset_n : synchronous active-low reset
//   sccb_io : bus bundle (slave modport), see sccb_target_responder_if
// Parameters:
//   DEV_ID      : 7-bit device address (write byte {DEV_ID,0}, read byte {DEV_ID,1})
//   SYNC_STAGES : synchronizer depth on SIOC/SIOD, must be at least 2
// Optional feature: define SCCB_RD_EN to enable register reads; otherwise read IDs are
// not ACKed and rd_addr is tied to 0.
module sccb_target_responder #(
  parameter logic [6:0]  DEV_ID      = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    clk_sys,
  input logic                    reset_n,
  sccb_target_responder_if.slave sccb_io
);

`ifdef SCCB_RD_EN
  localparam bit RdEn = 1'b1;
`else
  localparam bit RdEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StId, StAckId, StAddrH, StAckAh, StAddrL, StAckAl,
    StWdata, StAckWd, StRdata, StRack, StIgnore
  } state_e;

  // Top bit of each chain is the extra edge-detect flop. Reset to 1 (idle bus level).
  logic [SYNC_STAGES:0] scl_sync_q, sda_sync_q;
  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [15:0] ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_mode_q, rd_mode_d;
  logic        nack_q, nack_d;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-1:0], sccb_io.SIOC_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-1:0], sccb_io.SIOD_i};
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign scl_p     = scl_sync_q[SYNC_STAGES];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign sda_p     = sda_sync_q[SYNC_STAGES];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & ~sda_s & sda_p;
  assign stop_det  = scl_s & scl_p & sda_s & ~sda_p;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_hi_d  = addr_hi_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_mode_d  = rd_mode_q;
    nack_d     = nack_q;

    if (start_det) begin
      // Repeated start is legal from any state; a partial byte is simply dropped.
      state_d = StId;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StId, StAddrH, StAddrL, StWdata: begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
          if (state_q == StWdata && cnt_q == 4'd7) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = {shift_q[6:0], sda_s};
            ptr_d      = ptr_q + 16'd1;
          end
        end
        StRdata: cnt_d = cnt_q + 4'd1;
        StRack: begin
          // Advance on master ACK here so rd_data has settled by the falling edge.
          nack_d = sda_s;
          if (!sda_s) ptr_d = ptr_q + 16'd1;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        StId: begin
          if (cnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ID && (!shift_q[0] || RdEn)) begin
              state_d   = StAckId;
              oe_d      = 1'b1;
              rd_mode_d = shift_q[0];
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAckId: begin
          cnt_d = 4'd0;
          if (rd_mode_q) begin
            shift_d = sccb_io.rd_data;
            oe_d    = ~sccb_io.rd_data[7];
            state_d = StRdata;
          end else begin
            oe_d    = 1'b0;
            state_d = StAddrH;
          end
        end
        StAddrH: begin
          if (cnt_q == 4'd8) begin
            addr_hi_d = shift_q;
            oe_d      = 1'b1;
            state_d   = StAckAh;
          end
        end
        StAckAh: begin
          oe_d    = 1'b0;
          cnt_d   = 4'd0;
          state_d = StAddrL;
        end
        StAddrL: begin
          if (cnt_q == 4'd8) begin
            ptr_d   = {addr_hi_q, shift_q};
            oe_d    = 1'b1;
            state_d = StAckAl;
          end
        end
        StAckAl, StAckWd: begin
          oe_d    = 1'b0;
          cnt_d   = 4'd0;
          state_d = StWdata;
        end
        StWdata: begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b1;
            state_d = StAckWd;
          end
        end
        StRdata: begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = StRack;
          end else begin
            oe_d = ~shift_q[3'd7 - cnt_q[2:0]];
          end
        end
        StRack: begin
          if (nack_q) begin
            state_d = StIgnore;
          end else begin
            cnt_d   = 4'd0;
            shift_d = sccb_io.rd_data;
            oe_d    = ~sccb_io.rd_data[7];
            state_d = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      addr_hi_q  <= 8'd0;
      ptr_q      <= 16'd0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
      rd_mode_q  <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_hi_q  <= addr_hi_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_mode_q  <= rd_mode_d;
      nack_q     <= nack_d;
    end
  end

  assign sccb_io.SIOD_oe  = oe_q;
  assign sccb_io.busy     = busy_q;
  assign sccb_io.wr_valid = wr_valid_q;
  assign sccb_io.wr_addr  = wr_addr_q;
  assign sccb_io.wr_data  = wr_data_q;
  assign sccb_io.rd_addr  = RdEn ? ptr_q : 16'd0;

endmodule
